// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer memory: default widths, FSM state
// encoding and the byte-strobe merge helper used by the storage array.
package apb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PROT_WIDTH = 3;

    // Widest supported data bus; the merge helper works at this width and
    // callers truncate to their own word size.
    localparam int MAX_DW = 64;
    localparam int MAX_SW = MAX_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // Replace each byte of old_word whose strobe bit is set with the
    // corresponding byte of new_word.
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_SW-1:0] strb
    );
        logic [MAX_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_SW; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_completer_mem_if.sv
// APB4 master-side port bundle between a requester and apb_completer_mem.
interface apb_completer_mem_if
    import apb_pkg::*;
#(
    parameter int AW = DEF_ADDR_WIDTH,
    parameter int DW = DEF_DATA_WIDTH,
    parameter int PW = DEF_PROT_WIDTH
);
    logic            PSELM;
    logic            PENABLEM;
    logic [AW-1:0]   PADDRM;
    logic            PWRITEM;
    logic [DW-1:0]   PWDATAM;
    logic [PW-1:0]   PPROTM;
    logic [DW/8-1:0] PSTRBM;
    logic [DW-1:0]   PRDATAM;
    logic            PREADYM;
    logic            PSLVERRM;

    modport master (
        output PSELM, PENABLEM, PADDRM, PWRITEM, PWDATAM, PPROTM, PSTRBM,
        input  PRDATAM, PREADYM, PSLVERRM
    );

    modport slave (
        input  PSELM, PENABLEM, PADDRM, PWRITEM, PWDATAM, PPROTM, PSTRBM,
        output PRDATAM, PREADYM, PSLVERRM
    );

endinterface

// File: rtl/apb_cmp_regfile.sv
// DEPTH x DW word storage: synchronous clear, one byte-strobed write port and
// one combinational read port.
module apb_cmp_regfile
    import apb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic [IW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Clear all words on reset, otherwise merge strobed bytes into the addressed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= DW'(strb_merge(MAX_DW'(mem[waddr]), MAX_DW'(wdata), MAX_SW'(wstrb)));
        end
    end

    // Read port is asynchronous; the completer registers the result itself.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer backed by a byte-strobed word memory, with a fixed number
// of wait states and an error response for out-of-window/unaligned accesses.
// Optional: define APB_COMPLETER_PROT_CHECK_EN to reject unprivileged
// accesses to word indices at or above PRIV_BASE.
module apb_completer_mem
    import apb_pkg::*;
#(
    parameter int          APB_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int          APB_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int          APB_PROT_WIDTH = DEF_PROT_WIDTH,
    parameter int          DEPTH          = 64,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int          WAIT_STATES    = 0,
    parameter int          PRIV_BASE      = 32
) (
    input  logic                PCLKM,
    input  logic                PRESETM,
    apb_completer_mem_if.slave  bus
);

    localparam int AW    = APB_ADDR_WIDTH;
    localparam int DW    = APB_DATA_WIDTH;
    localparam int PW    = APB_PROT_WIDTH;
    localparam int SW    = DW / 8;
    localparam int LSB_W = $clog2(SW);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AW:0]   WIN_BYTES = (AW+1)'(DEPTH * SW);
    localparam logic [AW-1:0] BASE      = AW'(BASE_ADDR);

    cmp_state_e    state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;

    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] strb_q;
    logic [PW-1:0] prot_q;

    logic          setup;
    logic [AW-1:0] cur_addr;
    logic          cur_write;
    logic [DW-1:0] cur_wdata;
    logic [SW-1:0] cur_strb;
    logic [PW-1:0] cur_prot;

    logic [AW-1:0]    off;
    logic [IDX_W-1:0] idx;
    logic             acc_err;

    logic          enter_done;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          ready_nxt;
    logic          slverr_nxt;
    logic [DW-1:0] rdata_nxt;
    logic          unused_bits;

    assign setup = bus.PSELM & ~bus.PENABLEM;

    // With zero wait states DONE is entered straight from the setup cycle, so
    // the request is taken from the bus in IDLE and from the latches afterwards.
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = bus.PADDRM;
            cur_write = bus.PWRITEM;
            cur_wdata = bus.PWDATAM;
            cur_strb  = bus.PSTRBM;
            cur_prot  = bus.PPROTM;
        end else begin
            cur_addr  = addr_q;
            cur_write = write_q;
            cur_wdata = wdata_q;
            cur_strb  = strb_q;
            cur_prot  = prot_q;
        end
    end

    // Address decode and error classification for the current request.
    always_comb begin
        off     = cur_addr - BASE;
        idx     = off[LSB_W +: IDX_W];
        acc_err = (cur_addr < BASE) | ({1'b0, off} >= WIN_BYTES) | (off[LSB_W-1:0] != '0);
`ifdef APB_COMPLETER_PROT_CHECK_EN
        if (!cur_prot[0] && ({1'b0, idx} >= (IDX_W+1)'(PRIV_BASE))) acc_err = 1'b1;
`else
`endif
    end

    assign unused_bits = ^{off, cur_prot};

    // State and wait-counter register.
    always_ff @(posedge PCLKM) begin
        if (PRESETM) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: setup starts a transfer, WAIT counts down, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (setup) begin
                    cnt_nxt   = 4'(WAIT_STATES);
                    state_nxt = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!bus.PSELM) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: everything happens on the edge that enters DONE.
    always_comb begin
        enter_done = (state_nxt == DONE);
        mem_we     = enter_done & cur_write & ~acc_err;
        ready_nxt  = enter_done;
        slverr_nxt = enter_done & acc_err;
        rdata_nxt  = (enter_done & ~cur_write & ~acc_err) ? mem_rdata : '0;
    end

    // Registered bus outputs.
    always_ff @(posedge PCLKM) begin
        if (PRESETM) begin
            bus.PREADYM  <= 1'b0;
            bus.PSLVERRM <= 1'b0;
            bus.PRDATAM  <= '0;
        end else begin
            bus.PREADYM  <= ready_nxt;
            bus.PSLVERRM <= slverr_nxt;
            bus.PRDATAM  <= rdata_nxt;
        end
    end

    // Capture the request during the setup cycle for use in WAIT.
    always_ff @(posedge PCLKM) begin
        if (PRESETM) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
        end else if (state == IDLE && setup) begin
            addr_q  <= bus.PADDRM;
            write_q <= bus.PWRITEM;
            wdata_q <= bus.PWDATAM;
            strb_q  <= bus.PSTRBM;
            prot_q  <= bus.PPROTM;
        end
    end

    apb_cmp_regfile #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IDX_W)
    ) u_regfile (
        .clk   (PCLKM),
        .rst   (PRESETM),
        .we    (mem_we),
        .waddr (idx),
        .wdata (cur_wdata),
        .wstrb (cur_strb),
        .raddr (idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed bench: two completers, zero and three wait states, on separate buses.
module tb_apb_completer_mem;

    logic clk;
    logic rst0;
    logic rst1;
    int   checks;
    int   failures;

    apb_completer_mem_if #(.AW(32), .DW(32), .PW(3)) b0 ();
    apb_completer_mem_if #(.AW(32), .DW(32), .PW(3)) b1 ();

    apb_completer_mem #(.WAIT_STATES(0)) dut0 (.PCLKM(clk), .PRESETM(rst0), .bus(b0));
    apb_completer_mem #(.WAIT_STATES(3)) dut1 (.PCLKM(clk), .PRESETM(rst1), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot);
        if (which == 0) begin
            b0.PSELM = sel; b0.PENABLEM = en; b0.PWRITEM = wr; b0.PADDRM = addr;
            b0.PWDATAM = data; b0.PSTRBM = strb; b0.PPROTM = prot;
        end else begin
            b1.PSELM = sel; b1.PENABLEM = en; b1.PWRITEM = wr; b1.PADDRM = addr;
            b1.PWDATAM = data; b1.PSTRBM = strb; b1.PPROTM = prot;
        end
    endtask

    task automatic sample(input int which, output logic rdy, output logic [31:0] rd, output logic err);
        if (which == 0) begin
            rdy = b0.PREADYM; rd = b0.PRDATAM; err = b0.PSLVERRM;
        end else begin
            rdy = b1.PREADYM; rd = b1.PRDATAM; err = b1.PSLVERRM;
        end
    endtask

    task automatic idle(input int which);
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    endtask

    // One complete transfer; lat is the access cycle in which PREADYM was seen
    // (99 if it never came within the budget).
    task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                        output int lat, output logic [31:0] rd, output logic err);
        logic rdy;
        @(negedge clk);
        drive(which, 1'b1, 1'b0, wr, addr, data, strb, prot);
        @(negedge clk);
        drive(which, 1'b1, 1'b1, wr, addr, data, strb, prot);
        lat = 1;
        sample(which, rdy, rd, err);
        while (!rdy && lat < 32) begin
            @(negedge clk);
            lat++;
            sample(which, rdy, rd, err);
        end
        if (!rdy) lat = 99;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;
        logic        rdy;
        logic        seen;

        checks   = 0;
        failures = 0;
        rst0     = 1'b1;
        rst1     = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        repeat (3) @(negedge clk);

        sample(0, rdy, rd, err);
        check("rst0_ready", rdy, 1'b0);
        check("rst0_err", err, 1'b0);
        check("rst0_rdata", rd, 32'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        sample(1, rdy, rd, err);
        check("rst1_ready", rdy, 1'b0);
        check("rst1_rdata", rd, 32'h0);

        // Zero wait states: write then read back.
        xfer(0, 1'b1, 32'h08, 32'hA5A5_1234, 4'hF, 3'b001, lat, rd, err);
        check("t1_wr_lat", lat, 1);
        check("t1_wr_err", err, 1'b0);
        check("t1_wr_rdata", rd, 32'h0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t1_rd_lat", lat, 1);
        check("t1_rd_data", rd, 32'hA5A5_1234);
        check("t1_rd_err", err, 1'b0);
        idle(0);
        sample(0, rdy, rd, err);
        check("t1_ready_one_cycle", rdy, 1'b0);
        check("t1_rdata_idle", rd, 32'h0);

        // Three wait states.
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t2_rd_lat", lat, 4);
        check("t2_rd_data", rd, 32'h0);
        check("t2_rd_err", err, 1'b0);
        idle(1);
        sample(1, rdy, rd, err);
        check("t2_ready_one_cycle", rdy, 1'b0);

        // Byte strobes, back-to-back transfers.
        xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, 3'b001, lat, rd, err);
        xfer(0, 1'b1, 32'h10, 32'h1122_3344, 4'h5, 3'b001, lat, rd, err);
        check("t3_b2b_lat", lat, 1);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t3_merge", rd, 32'hFF22_FF44);
        xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'h0, 3'b001, lat, rd, err);
        check("t3_strb0_err", err, 1'b0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t3_strb0_nowrite", rd, 32'hA5A5_1234);

        // Decode errors.
        xfer(0, 1'b0, 32'h100, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t4_oor_err", err, 1'b1);
        check("t4_oor_rdata", rd, 32'h0);
        check("t4_oor_lat", lat, 1);
        xfer(0, 1'b0, 32'h02, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t4_unal_err", err, 1'b1);
        check("t4_unal_rdata", rd, 32'h0);
        xfer(0, 1'b1, 32'h0A, 32'hDEAD_BEEF, 4'hF, 3'b001, lat, rd, err);
        check("t4_unal_wr_err", err, 1'b1);
        xfer(0, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 3'b001, lat, rd, err);
        check("t4_oor_wr_err", err, 1'b1);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t4_mem_unchanged", rd, 32'hA5A5_1234);
        check("t4_ok_err", err, 1'b0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t4_wrap_unchanged", rd, 32'h0);

        // Enable without a preceding setup is ignored.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h7777_7777, 4'hF, 3'b001);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sample(0, rdy, rd, err);
            seen = seen | rdy;
        end
        check("enable_only_ignored", seen, 1'b0);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("enable_only_nowrite", rd, 32'h0);

        // Select dropped during WAIT aborts the write.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h08, 32'h5555_AAAA, 4'hF, 3'b001);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h08, 32'h5555_AAAA, 4'hF, 3'b001);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
            sample(1, rdy, rd, err);
            seen = seen | rdy;
        end
        check("abort_no_ready", seen, 1'b0);
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("abort_nowrite", rd, 32'h0);
        check("abort_next_lat", lat, 4);

        // Reset during WAIT drops the pending write.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h04, 32'h1234_5678, 4'hF, 3'b001);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h04, 32'h1234_5678, 4'hF, 3'b001);
        @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        sample(1, rdy, rd, err);
        check("t5_rst_ready", rdy, 1'b0);
        check("t5_rst_err", err, 1'b0);
        check("t5_rst_rdata", rd, 32'h0);
        @(negedge clk);
        rst1 = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            sample(1, rdy, rd, err);
            seen = seen | rdy;
        end
        check("t5_no_late_ready", seen, 1'b0);
        idle(1);
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t5_write_dropped", rd, 32'h0);

        // Privileged region at word index 32 (byte 0x80).
        xfer(0, 1'b1, 32'h80, 32'hCAFE_F00D, 4'hF, 3'b000, lat, rd, err);
`ifdef APB_COMPLETER_PROT_CHECK_EN
        check("t6_unpriv_wr_err", err, 1'b1);
`else
        check("t6_unpriv_wr_err", err, 1'b0);
`endif
        xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, 3'b001, lat, rd, err);
`ifdef APB_COMPLETER_PROT_CHECK_EN
        check("t6_unpriv_wr_data", rd, 32'h0);
`else
        check("t6_unpriv_wr_data", rd, 32'hCAFE_F00D);
`endif
        xfer(0, 1'b1, 32'h80, 32'h0BAD_C0DE, 4'hF, 3'b001, lat, rd, err);
        check("t6_priv_wr_err", err, 1'b0);
        xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, 3'b001, lat, rd, err);
        check("t6_priv_rd_data", rd, 32'h0BAD_C0DE);
        check("t6_priv_rd_err", err, 1'b0);
        xfer(0, 1'b0, 32'h7C, 32'h0, 4'h0, 3'b000, lat, rd, err);
        check("t6_below_priv_err", err, 1'b0);
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
